// File: rtl/denise_pkg.sv
// ---------------------------------------------------------------------------
// denise_pkg
// Shared helpers for the Denise sprite/playfield priority and collision block.
//   clx_width(ngrp)       : width of the sticky collision register
//   pair_bit(ngrp, i, j)  : collision bit index for sprite pair i vs pair j (i<j)
//   none_code(priw)       : "no sprite" group code (all ones of priw bits)
// ---------------------------------------------------------------------------
package denise_pkg;

  // One PF1/PF2 bit, one bit per pair per playfield, one bit per pair-pair.
  function automatic int clx_width(input int ngrp);
    return 1 + 2 * ngrp + (ngrp * (ngrp - 1)) / 2;
  endfunction

  // Pair-pair bits follow the playfield bits in lexicographic (i,j) order.
  // Offset of row i is the count of pairs (k,j) with k<i.
  function automatic int pair_bit(input int ngrp, input int i, input int j);
    return 1 + 2 * ngrp + i * (ngrp - 1) - (i * (i - 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int none_code(input int priw);
    return (1 << priw) - 1;
  endfunction

endpackage

// File: rtl/denise_sprite_prienc.sv
// ---------------------------------------------------------------------------
// denise_sprite_prienc
// Groups sprite video flags into pairs and priority-encodes them; the lowest
// active pair wins. Purely combinational.
//   i_nsprite : per-sprite non-transparent flags (NSPR bits)
//   o_code    : g+1 for the lowest active pair g, all ones when none active
// ---------------------------------------------------------------------------
module denise_sprite_prienc
  import denise_pkg::*;
#(
  parameter int NSPR = 8,
  parameter int PRIW = 3
) (
  input  logic [NSPR-1:0] i_nsprite,
  output logic [PRIW-1:0] o_code
);

  localparam int NGRP = NSPR / 2;

  logic [NGRP-1:0] w_act;

  for (genvar g = 0; g < NGRP; g++) begin : g_pair
    assign w_act[g] = i_nsprite[2*g] | i_nsprite[2*g+1];
  end

  // Scan from the highest pair down so the lowest active pair is written last.
  always_comb begin
    o_code = PRIW'(none_code(PRIW));
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (w_act[g]) o_code = PRIW'(g + 1);
    end
  end

endmodule

// File: rtl/denise_priority_collision.sv
// ---------------------------------------------------------------------------
// denise_priority_collision
// Two-stage sprite/playfield priority select plus sticky collision register.
//   clk, reset_n  : clock, asynchronous active-low reset
//   clk7_en       : pixel-rate enable for pipeline and collision capture
//   bplcon2       : [PRIW-1:0] PF1 priority field, [2*PRIW-1:PRIW] PF2 field
//   nplayfield    : [1] PF1, [2] PF2 non-transparent flags
//   nsprite       : per-sprite non-transparent flags
//   clxcon_ensp   : per-pair enable of the odd sprite for collision detection
//   clxdat_rd     : single-clk read strobe, clears the collision register
//   sprsel        : 1 = sprite pixel wins, 0 = playfield
//   sprcode       : winning pair code aligned with sprsel
//   clxdat        : sticky collision bits
// A sprite pair is hidden behind a visible playfield whose priority field is
// smaller than the pair code; field >= NGRP therefore never hides a pair.
// ---------------------------------------------------------------------------
module denise_priority_collision
  import denise_pkg::*;
#(
  parameter  int NSPR = 8,
  parameter  int PRIW = 3,
  localparam int NGRP = NSPR / 2,
  localparam int CW   = clx_width(NSPR / 2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk7_en,
  input  logic [2*PRIW-1:0] bplcon2,
  input  logic [2:1]        nplayfield,
  input  logic [NSPR-1:0]   nsprite,
  input  logic [NGRP-1:0]   clxcon_ensp,
  input  logic              clxdat_rd,
  output logic              sprsel,
  output logic [PRIW-1:0]   sprcode,
  output logic [CW-1:0]     clxdat
);

  localparam logic [PRIW-1:0] NONE = PRIW'(none_code(PRIW));

  function automatic logic sprite_wins(
    input logic [PRIW-1:0] code,
    input logic [PRIW-1:0] pf1_pri,
    input logic [PRIW-1:0] pf2_pri,
    input logic [2:1]      npf
  );
    if (code == NONE)                 return 1'b0;
    else if (code > pf1_pri && npf[1]) return 1'b0;
    else if (code > pf2_pri && npf[2]) return 1'b0;
    else                              return 1'b1;
  endfunction

  logic [PRIW-1:0] w_code_p0;
  logic [PRIW-1:0] r_code_p1;
  logic [2:1]      r_npf_p1;
  logic            w_sel_p1;
  logic            r_sel_p2;
  logic [PRIW-1:0] r_code_p2;
  logic [NGRP-1:0] w_s;
  logic [CW-1:0]   w_hits;
  logic [CW-1:0]   r_clxdat;

  denise_sprite_prienc #(
    .NSPR (NSPR),
    .PRIW (PRIW)
  ) u_prienc (
    .i_nsprite (nsprite),
    .o_code    (w_code_p0)
  );

  // Stage 1: register the winning pair code and playfield flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_code_p1 <= NONE;
      r_npf_p1  <= '0;
    end else if (clk7_en) begin
      r_code_p1 <= w_code_p0;
      r_npf_p1  <= nplayfield;
    end
  end

  assign w_sel_p1 = sprite_wins(r_code_p1, bplcon2[PRIW-1:0],
                                bplcon2[2*PRIW-1:PRIW], r_npf_p1);

  // Stage 2: registered sprite select and aligned code
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_p2  <= 1'b0;
      r_code_p2 <= NONE;
    end else if (clk7_en) begin
      r_sel_p2  <= w_sel_p1;
      r_code_p2 <= r_code_p1;
    end
  end

  // Collision hits come straight from the current pixel inputs.
  for (genvar g = 0; g < NGRP; g++) begin : g_clx_s
    assign w_s[g] = nsprite[2*g] | (nsprite[2*g+1] & clxcon_ensp[g]);
  end

  always_comb begin
    w_hits    = '0;
    w_hits[0] = nplayfield[1] & nplayfield[2];
    for (int g = 0; g < NGRP; g++) begin
      w_hits[1 + g]        = nplayfield[1] & w_s[g];
      w_hits[1 + NGRP + g] = nplayfield[2] & w_s[g];
    end
    for (int i = 0; i < NGRP - 1; i++) begin
      for (int j = i + 1; j < NGRP; j++) begin
        w_hits[pair_bit(NGRP, i, j)] = w_s[i] & w_s[j];
      end
    end
  end

  // A read clears the register but keeps hits captured on the same edge;
  // the read is honoured even between pixel enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clxdat <= '0;
    end else if (clxdat_rd) begin
      r_clxdat <= clk7_en ? w_hits : '0;
    end else if (clk7_en) begin
      r_clxdat <= r_clxdat | w_hits;
    end
  end

  assign sprsel  = r_sel_p2;
  assign sprcode = r_code_p2;
  assign clxdat  = r_clxdat;

endmodule

// File: tb/tb_denise_priority_collision.sv
module tb_denise_priority_collision;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, clk7_en, clxdat_rd;

  // Default configuration: NSPR=8, PRIW=3 (4 pairs, 15 collision bits)
  logic [5:0]  a_bpl;
  logic [2:1]  a_npf;
  logic [7:0]  a_spr;
  logic [3:0]  a_ens;
  logic        a_sel;
  logic [2:0]  a_code;
  logic [14:0] a_clx;

  // Wide configuration: NSPR=12, PRIW=4 (6 pairs, 28 collision bits)
  logic [7:0]  b_bpl;
  logic [2:1]  b_npf;
  logic [11:0] b_spr;
  logic [5:0]  b_ens;
  logic        b_sel;
  logic [3:0]  b_code;
  logic [27:0] b_clx;

  denise_priority_collision #(.NSPR(8), .PRIW(3)) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk7_en     (clk7_en),
    .bplcon2     (a_bpl),
    .nplayfield  (a_npf),
    .nsprite     (a_spr),
    .clxcon_ensp (a_ens),
    .clxdat_rd   (clxdat_rd),
    .sprsel      (a_sel),
    .sprcode     (a_code),
    .clxdat      (a_clx)
  );

  denise_priority_collision #(.NSPR(12), .PRIW(4)) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk7_en     (clk7_en),
    .bplcon2     (b_bpl),
    .nplayfield  (b_npf),
    .nsprite     (b_spr),
    .clxcon_ensp (b_ens),
    .clxdat_rd   (clxdat_rd),
    .sprsel      (b_sel),
    .sprcode     (b_code),
    .clxdat      (b_clx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: what each output should be after an edge.
  typedef struct {
    logic [31:0] code1;
    logic [1:0]  npf1;
    logic        sel;
    logic [31:0] code;
    logic [31:0] clx;
    int          quiet;
    logic [31:0] bpl_last;
  } mstate_t;

  mstate_t ma, mb;

  function automatic logic [31:0] ref_code(input int ngrp, input int priw, input logic [31:0] spr);
    for (int g = 0; g < ngrp; g++)
      if (spr[2*g] || spr[2*g+1]) return 32'(g + 1);
    return (32'd1 << priw) - 32'd1;
  endfunction

  // npf[0] = PF1 visible, npf[1] = PF2 visible
  function automatic logic ref_sel(input int priw, input logic [31:0] code,
                                   input logic [31:0] bpl, input logic [1:0] npf);
    logic [31:0] none, f1, f2;
    none = (32'd1 << priw) - 32'd1;
    f1   = bpl & none;
    f2   = (bpl >> priw) & none;
    if (code == none) return 1'b0;
    if (npf[0] && code > f1) return 1'b0;
    if (npf[1] && code > f2) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_hits(input int ngrp, input logic [31:0] spr,
                                           input logic [31:0] ens, input logic [1:0] npf);
    logic [15:0] s;
    logic [31:0] h;
    int k;
    s = '0;
    h = '0;
    for (int g = 0; g < ngrp; g++) s[g] = spr[2*g] | (spr[2*g+1] & ens[g]);
    h[0] = npf[0] & npf[1];
    k = 1;
    for (int g = 0; g < ngrp; g++) begin h[k] = npf[0] & s[g]; k++; end
    for (int g = 0; g < ngrp; g++) begin h[k] = npf[1] & s[g]; k++; end
    for (int i = 0; i < ngrp; i++)
      for (int j = i + 1; j < ngrp; j++) begin h[k] = s[i] & s[j]; k++; end
    return h;
  endfunction

  task automatic model_edge(inout mstate_t m, input int ngrp, input int priw,
                            input logic [31:0] bpl, input logic [31:0] spr,
                            input logic [31:0] ens, input logic [1:0] npf);
    logic [31:0] hits;
    logic [31:0] none;
    none = (32'd1 << priw) - 32'd1;
    if (!reset_n) begin
      m.code1 = none; m.npf1 = '0; m.sel = 1'b0; m.code = none; m.clx = '0;
      m.quiet = 0; m.bpl_last = bpl;
      return;
    end
    hits = ref_hits(ngrp, spr, ens, npf);
    if (bpl != m.bpl_last) begin
      m.quiet = 0;
      m.bpl_last = bpl;
    end
    if (clk7_en) begin
      m.sel   = ref_sel(priw, m.code1, bpl, m.npf1);
      m.code  = m.code1;
      m.code1 = ref_code(ngrp, priw, spr);
      m.npf1  = npf;
      m.quiet++;
    end
    if (clxdat_rd) m.clx = clk7_en ? hits : 32'd0;
    else if (clk7_en) m.clx = m.clx | hits;
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  // sprsel is compared once the priority fields have been steady for two
  // enabled edges.
  task automatic tick();
    @(posedge clk);
    model_edge(ma, 4, 3, 32'(a_bpl), 32'(a_spr), 32'(a_ens), {a_npf[2], a_npf[1]});
    model_edge(mb, 6, 4, 32'(b_bpl), 32'(b_spr), 32'(b_ens), {b_npf[2], b_npf[1]});
    #1;
    check("a_sprcode", 32'(a_code), ma.code);
    check("a_clxdat",  32'(a_clx),  ma.clx);
    if (ma.quiet >= 2) check("a_sprsel", 32'(a_sel), 32'(ma.sel));
    check("b_sprcode", 32'(b_code), mb.code);
    check("b_clxdat",  32'(b_clx),  mb.clx);
    if (mb.quiet >= 2) check("b_sprsel", 32'(b_sel), 32'(mb.sel));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nen;

    // Reset with random inputs
    reset_n = 1'b0; clk7_en = 1'b1; clxdat_rd = 1'b0;
    a_bpl = 6'($urandom); a_npf = 2'($urandom); a_spr = 8'($urandom); a_ens = 4'($urandom);
    b_bpl = 8'($urandom); b_npf = 2'($urandom); b_spr = 12'($urandom); b_ens = 6'($urandom);
    repeat (3) begin
      clxdat_rd = 1'($urandom);
      tick();
    end
    check("rst_a_sprsel",  32'(a_sel),  32'd0);
    check("rst_a_sprcode", 32'(a_code), 32'd7);
    check("rst_a_clxdat",  32'(a_clx),  32'd0);
    check("rst_b_sprcode", 32'(b_code), 32'd15);
    check("rst_b_clxdat",  32'(b_clx),  32'd0);

    // Release reset; pair 1 visible in front of both playfields,
    // enable every 4th clock: output changes only after the 2nd enabled edge.
    clxdat_rd = 1'b0;
    a_bpl = 6'o77; a_spr = 8'h04; a_npf = 2'b11; a_ens = 4'b0000;
    b_bpl = 8'h00; b_spr = 12'h000; b_npf = 2'b00; b_ens = 6'b000000;
    reset_n = 1'b1;
    nen = 0;
    for (int k = 0; k < 12; k++) begin
      clk7_en = (k % 4 == 0);
      tick();
      if (k % 4 == 0) nen++;
      check("lat_sprcode", 32'(a_code), (nen >= 2) ? 32'd2 : 32'd7);
      check("lat_sprsel",  32'(a_sel),  (nen >= 2) ? 32'd1 : 32'd0);
    end

    // PF1 priority sweep with pair 3 (code 4) and PF1 visible
    clk7_en = 1'b1;
    a_spr = 8'h40; a_npf = 2'b01;
    for (int f = 0; f < 8; f++) begin
      a_bpl = 6'(f);
      tick(); tick();
      check("pf1_sweep", 32'(a_sel), (f >= 4) ? 32'd1 : 32'd0);
    end
    // PF2 sweep, PF1 field parked at 7, only PF2 visible
    a_npf = 2'b10;
    for (int f = 0; f < 8; f++) begin
      a_bpl = 6'((f << 3) | 7);
      tick(); tick();
      check("pf2_sweep", 32'(a_sel), (f >= 4) ? 32'd1 : 32'd0);
    end

    // Odd sprites only count when enabled
    a_npf = 2'b00; a_spr = 8'h0A; a_ens = 4'b0000;
    clxdat_rd = 1'b1; tick();
    clxdat_rd = 1'b0; tick();
    check("clx_ensp_off", 32'(a_clx), 32'h0000);
    a_ens = 4'b0011;
    clxdat_rd = 1'b1; tick();
    check("clx_ensp_on", 32'(a_clx), 32'h0200);
    a_npf = 2'b11;
    tick();
    check("clx_ensp_pf", 32'(a_clx), 32'h0267);

    // Read/clear race
    a_spr = 8'h00; a_npf = 2'b11; a_ens = 4'b0000;
    tick();
    a_npf = 2'b00; clxdat_rd = 1'b0;
    tick();
    check("race_pre", 32'(a_clx), 32'h0001);
    a_spr = 8'h40; a_npf = 2'b01; clxdat_rd = 1'b1;
    tick();
    check("race_rd_en", 32'(a_clx), 32'h0010);
    clk7_en = 1'b0;
    tick();
    check("race_rd_noen", 32'(a_clx), 32'h0000);
    clxdat_rd = 1'b0; clk7_en = 1'b1;

    // Wide configuration: pair 5 via its odd sprite, then pairs 4 and 5
    b_bpl = 8'hFF; b_spr = 12'h800; b_npf = 2'b01; b_ens = 6'b100000;
    clxdat_rd = 1'b1; tick();
    clxdat_rd = 1'b0; tick(); tick();
    check("wide_sprcode", 32'(b_code), 32'd6);
    check("wide_pf1_s5",  32'(b_clx),  32'h0000040);
    b_spr = 12'h900; b_npf = 2'b00;
    clxdat_rd = 1'b1; tick();
    check("wide_s4_s5",   32'(b_clx),  32'h8000000);
    clxdat_rd = 1'b0;

    // Randomized traffic against the reference model
    for (int blk = 0; blk < 4; blk++) begin
      a_bpl = 6'($urandom);
      b_bpl = 8'($urandom);
      for (int n = 0; n < 60; n++) begin
        clk7_en   = ($urandom % 3) != 0;
        clxdat_rd = ($urandom % 8) == 0;
        a_spr = 8'($urandom & $urandom);
        a_npf = 2'($urandom);
        a_ens = 4'($urandom);
        b_spr = 12'($urandom & $urandom & $urandom);
        b_npf = 2'($urandom);
        b_ens = 6'($urandom);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
